// File: rtl/mem_block_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_responder_if
// Purpose  : Request/response bundle between the cache refill port and the
//            block memory responder.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_block_responder_if #(
  parameter int Word_Size  = 32,
  parameter int Block_Size = 4
);
  logic                          mem_req;
  logic                          mem_we;
  logic [Word_Size-1:0]          mem_addr;
  logic [Block_Size-1:0]         mem_wmask;
  logic [Word_Size*Block_Size-1:0] mem_wdata;
  logic [Word_Size*Block_Size-1:0] mem_rdata;
  logic                          mem_ready;
  logic                          mem_busy;

  // Requester side (cache controller)
  modport master (
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_rdata, mem_ready, mem_busy
  );

  // Responder side (memory)
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_rdata, mem_ready, mem_busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_block_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_responder
// Purpose  : Block-organised main-memory model with fixed access latency,
//            serving block reads and per-word masked writes over a four-phase
//            req/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mem_block_responder #(
  parameter int Word_Size  = 32,
  parameter int Block_Size = 4,
  parameter int Mem_Blocks = 1024,
  parameter int Latency    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_block_responder_if.slave  bus
);

  localparam int BLK_W = Word_Size * Block_Size;
  localparam int OFF_W = $clog2(Block_Size * 4);
  localparam int IDX_W = $clog2(Mem_Blocks);
  localparam logic [7:0] CNT_LOAD = 8'(Latency - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [7:0]        count;
  logic [7:0]        next_count;
  logic              accept;
  logic              perform;

  logic              lat_we;
  logic [IDX_W-1:0]  lat_idx;
  logic [Block_Size-1:0] lat_mask;
  logic [BLK_W-1:0]  lat_wdata;
  logic [BLK_W-1:0]  rdata_q;

  logic [BLK_W-1:0]  storage [Mem_Blocks];

  // Offset and alias bits of the address are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^bus.mem_addr;

  // Next-state, counter and strobe decode.
  always_comb begin
    next_state = state;
    next_count = count;
    accept     = 1'b0;
    perform    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.mem_req) begin
          accept     = 1'b1;
          next_state = S_BUSY;
          next_count = CNT_LOAD;
        end
      end
      S_BUSY: begin
        if (count == 8'd0) begin
          perform    = 1'b1;
          next_state = S_RESP;
        end else begin
          next_count = count - 8'd1;
        end
      end
      S_RESP: begin
        if (!bus.mem_req) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
        next_count = 8'd0;
      end
    endcase
  end

  // State, counter, request latch and read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= 8'd0;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (accept) begin
        lat_we    <= bus.mem_we;
        lat_idx   <= bus.mem_addr[OFF_W+IDX_W-1:OFF_W];
        lat_mask  <= bus.mem_wmask;
        lat_wdata <= bus.mem_wdata;
      end
      if (perform && !lat_we) begin
        rdata_q <= storage[lat_idx];
      end
    end
  end

  // Storage write; reset during BUSY suppresses the access, contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && perform && lat_we) begin
      for (int i = 0; i < Block_Size; i++) begin
        if (lat_mask[i]) begin
          storage[lat_idx][i*Word_Size +: Word_Size] <= lat_wdata[i*Word_Size +: Word_Size];
        end
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = (state == S_RESP);
  assign bus.mem_busy  = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_block_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_block_responder
// Purpose  : Self-checking bench for mem_block_responder against a
//            block-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_block_responder;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_block_responder_if #(.Word_Size(32), .Block_Size(4)) bus ();
  mem_block_responder_if #(.Word_Size(32), .Block_Size(4)) bus1 ();

  mem_block_responder #(.Word_Size(32), .Block_Size(4), .Mem_Blocks(1024), .Latency(10)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mem_block_responder #(.Word_Size(32), .Block_Size(4), .Mem_Blocks(1024), .Latency(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Reference model: one 128-bit entry per block.
  logic [127:0] model [1024];

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr / 32'd16) % 32'd1024);
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [3:0] mask, input logic [127:0] wd);
    int b = idx_of(addr);
    for (int w = 0; w < 4; w++)
      if (mask[w]) model[b][w*32 +: 32] = wd[w*32 +: 32];
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one full handshake on the Latency=10 instance and reports observations.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [127:0] wd, input int hold, input bit churn,
                      output int lat, output logic [127:0] rd,
                      output bit hold_ok, output bit idle_ok);
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wmask = mask;
    bus.mem_wdata = wd;
    @(posedge clk); #1;
    lat = 0;
    do begin
      @(negedge clk);
      if (churn) begin
        bus.mem_we    = $urandom_range(1, 0) != 0;
        bus.mem_addr  = $urandom;
        bus.mem_wmask = 4'($urandom);
        bus.mem_wdata = rand_block();
      end
      @(posedge clk); #1;
      lat++;
    end while (!bus.mem_ready && lat < 300);
    rd = bus.mem_rdata;
    hold_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!bus.mem_ready || !bus.mem_busy || bus.mem_rdata !== rd) hold_ok = 1'b0;
    end
    @(negedge clk);
    bus.mem_req = 1'b0;
    @(posedge clk); #1;
    idle_ok = !bus.mem_ready && !bus.mem_busy;
  endtask

  task automatic test_reset();
    bit ok = 1'b1;
    int n;
    reset = 1'b1;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h0;
    bus.mem_wmask = 4'h0; bus.mem_wdata = '0;
    bus1.mem_req = 1'b0; bus1.mem_we = 1'b0; bus1.mem_addr = 32'h0;
    bus1.mem_wmask = 4'h0; bus1.mem_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.mem_ready !== 1'b0 || bus.mem_busy !== 1'b0 || bus.mem_rdata !== 128'h0) ok = 1'b0;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL reset_hold: ready=%b busy=%b rdata=%h, required 0/0/0",
               bus.mem_ready, bus.mem_busy, bus.mem_rdata);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.mem_busy !== 1'b1 || bus.mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_accept: busy=%b ready=%b, required 1/0", bus.mem_busy, bus.mem_ready);
    end
    n = 0;
    while (!bus.mem_ready && n < 40) begin @(posedge clk); #1; n++; end
    vectors++;
    if (n != 10) begin
      miscompares++;
      $display("FAIL reset_first_latency: got %0d cycles, required 10", n);
    end
    @(negedge clk); bus.mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat; logic [127:0] rd; bit h, idl;
    logic [127:0] d = {32'h4, 32'h3, 32'h2, 32'h77};
    xact(1'b1, 32'hFF0, 4'hF, d, 0, 1'b0, lat, rd, h, idl);
    model_write(32'hFF0, 4'hF, d);
    vectors++;
    if (lat != 10 || !idl) begin
      miscompares++;
      $display("FAIL write_latency: got %0d idle=%b, required 10 idle=1", lat, idl);
    end
    xact(1'b0, 32'hFF0, 4'h0, '0, 0, 1'b0, lat, rd, h, idl);
    vectors++;
    if (rd !== model[idx_of(32'hFF0)] || lat != 10) begin
      miscompares++;
      $display("FAIL read_ff0: got %h lat %0d, required %h lat 10", rd, lat, model[idx_of(32'hFF0)]);
    end
    xact(1'b0, 32'h4FF0, 4'h0, '0, 0, 1'b0, lat, rd, h, idl);
    vectors++;
    if (rd !== d) begin
      miscompares++;
      $display("FAIL read_alias: got %h, required %h", rd, d);
    end
  endtask

  task automatic test_masked_write();
    int lat; logic [127:0] rd; bit h, idl;
    logic [127:0] w = {32'hDEAD, 32'hDEAD, 32'hDEAD, 32'h88};
    logic [127:0] exp_d = {32'h4, 32'h3, 32'h2, 32'h88};
    xact(1'b1, 32'hFF0, 4'b0001, w, 0, 1'b0, lat, rd, h, idl);
    model_write(32'hFF0, 4'b0001, w);
    vectors++;
    if (rd !== {32'h4, 32'h3, 32'h2, 32'h77}) begin
      miscompares++;
      $display("FAIL rdata_held_on_write: got %h, required last read data", rd);
    end
    xact(1'b0, 32'hFF0, 4'h0, '0, 0, 1'b0, lat, rd, h, idl);
    vectors++;
    if (rd !== exp_d || rd !== model[idx_of(32'hFF0)]) begin
      miscompares++;
      $display("FAIL masked_write: got %h, required %h", rd, exp_d);
    end
    xact(1'b1, 32'hFF0, 4'b0000, rand_block(), 0, 1'b0, lat, rd, h, idl);
    xact(1'b0, 32'hFF0, 4'h0, '0, 0, 1'b0, lat, rd, h, idl);
    vectors++;
    if (rd !== exp_d || lat != 10 || !idl) begin
      miscompares++;
      $display("FAIL zero_mask_write: got %h lat %0d, required %h lat 10", rd, lat, exp_d);
    end
  endtask

  task automatic test_handshake_hold();
    int lat; logic [127:0] rd; bit h, idl;
    bit quiet = 1'b1;
    xact(1'b0, 32'hFF0, 4'h0, '0, 5, 1'b0, lat, rd, h, idl);
    vectors++;
    if (!h || !idl || rd !== model[idx_of(32'hFF0)]) begin
      miscompares++;
      $display("FAIL handshake_hold: hold_ok=%b idle=%b rdata=%h, required 1/1/%h",
               h, idl, rd, model[idx_of(32'hFF0)]);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.mem_busy || bus.mem_ready) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL single_access: busy/ready seen after release, required idle");
    end
  endtask

  task automatic test_abort();
    int lat; logic [127:0] rd; bit h, idl;
    bit no_ready = 1'b1;
    logic [127:0] p = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    logic [127:0] q = rand_block();
    xact(1'b1, 32'h100, 4'hF, p, 0, 1'b0, lat, rd, h, idl);
    model_write(32'h100, 4'hF, p);
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h100;
    bus.mem_wmask = 4'hF; bus.mem_wdata = {4{32'h55}};
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.mem_ready) no_ready = 1'b0;
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (!no_ready || bus.mem_ready !== 1'b0 || bus.mem_busy !== 1'b0 || bus.mem_rdata !== 128'h0) begin
      miscompares++;
      $display("FAIL abort_busy_outputs: ready=%b busy=%b rdata=%h, required 0/0/0",
               bus.mem_ready, bus.mem_busy, bus.mem_rdata);
    end
    @(negedge clk); reset = 1'b0; bus.mem_req = 1'b0;
    @(posedge clk); #1;
    xact(1'b1, 32'h100, 4'b0001, {96'h0, 32'h11}, 0, 1'b0, lat, rd, h, idl);
    model_write(32'h100, 4'b0001, {96'h0, 32'h11});
    xact(1'b0, 32'h100, 4'h0, '0, 0, 1'b0, lat, rd, h, idl);
    vectors++;
    if (rd !== {p[127:32], 32'h11}) begin
      miscompares++;
      $display("FAIL abort_no_write: got %h, required %h", rd, {p[127:32], 32'h11});
    end
    // Reset while in RESP keeps the completed write.
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h200;
    bus.mem_wmask = 4'hF; bus.mem_wdata = q;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.mem_ready && lat < 300);
    model_write(32'h200, 4'hF, q);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.mem_ready !== 1'b0 || bus.mem_busy !== 1'b0 || bus.mem_rdata !== 128'h0) begin
      miscompares++;
      $display("FAIL abort_resp_outputs: ready=%b busy=%b rdata=%h, required 0/0/0",
               bus.mem_ready, bus.mem_busy, bus.mem_rdata);
    end
    @(negedge clk); reset = 1'b0; bus.mem_req = 1'b0;
    @(posedge clk); #1;
    xact(1'b0, 32'h200, 4'h0, '0, 0, 1'b0, lat, rd, h, idl);
    vectors++;
    if (rd !== q) begin
      miscompares++;
      $display("FAIL resp_reset_write_kept: got %h, required %h", rd, q);
    end
  endtask

  task automatic test_latency1();
    logic [127:0] q = rand_block();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      bus1.mem_req = 1'b1; bus1.mem_we = (pass == 0); bus1.mem_addr = 32'h30;
      bus1.mem_wmask = 4'hF; bus1.mem_wdata = q;
      @(posedge clk); #1;
      vectors++;
      if (bus1.mem_busy !== 1'b1 || bus1.mem_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL lat1_accept: busy=%b ready=%b, required 1/0", bus1.mem_busy, bus1.mem_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus1.mem_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL lat1_ready: ready=%b, required 1", bus1.mem_ready);
      end
      if (pass == 1) begin
        vectors++;
        if (bus1.mem_rdata !== q) begin
          miscompares++;
          $display("FAIL lat1_readback: got %h, required %h", bus1.mem_rdata, q);
        end
      end
      @(negedge clk); bus1.mem_req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_churn();
    int lat; logic [127:0] rd; bit h, idl;
    logic [127:0] c = rand_block();
    xact(1'b1, 32'h500, 4'hF, c, 0, 1'b1, lat, rd, h, idl);
    model_write(32'h500, 4'hF, c);
    xact(1'b0, 32'h500, 4'h0, '0, 0, 1'b1, lat, rd, h, idl);
    vectors++;
    if (rd !== c) begin
      miscompares++;
      $display("FAIL churn_latched: got %h, required %h", rd, c);
    end
    xact(1'b0, 32'hFF0, 4'h0, '0, 0, 1'b0, lat, rd, h, idl);
    vectors++;
    if (rd !== model[idx_of(32'hFF0)]) begin
      miscompares++;
      $display("FAIL churn_no_stray: got %h, required %h", rd, model[idx_of(32'hFF0)]);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [127:0] rd; bit h, idl;
    int blks [8];
    logic [127:0] last_rd;
    for (int i = 0; i < 8; i++) begin
      blks[i] = (i * 37 + 5) % 1024;
      xact(1'b1, 32'(blks[i] * 16), 4'hF, rand_block(), 0, 1'b0, lat, rd, h, idl);
      model_write(32'(blks[i] * 16), 4'hF, bus.mem_wdata);
    end
    xact(1'b0, 32'(blks[0] * 16), 4'h0, '0, 0, 1'b0, lat, rd, h, idl);
    last_rd = rd;
    for (int n = 0; n < 40; n++) begin
      logic we; logic [31:0] a; logic [3:0] m; logic [127:0] d;
      we = $urandom_range(1, 0) != 0;
      a  = 32'(blks[$urandom_range(7, 0)] * 16) + 32'($urandom_range(15, 0))
           + 32'($urandom_range(3, 0)) * 32'h4000;
      m  = 4'($urandom);
      d  = rand_block();
      xact(we, a, m, d, $urandom_range(2, 0), 1'b0, lat, rd, h, idl);
      vectors++;
      if (lat != 10 || !h || !idl) begin
        miscompares++;
        $display("FAIL b2b_handshake[%0d]: lat=%0d hold=%b idle=%b, required 10/1/1", n, lat, h, idl);
      end
      vectors++;
      if (we) begin
        model_write(a, m, d);
        if (rd !== last_rd) begin
          miscompares++;
          $display("FAIL b2b_rdata_hold[%0d]: got %h, required %h", n, rd, last_rd);
        end
      end else begin
        if (rd !== model[idx_of(a)]) begin
          miscompares++;
          $display("FAIL b2b_read[%0d] addr %h: got %h, required %h", n, a, rd, model[idx_of(a)]);
        end
        last_rd = model[idx_of(a)];
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_handshake_hold();
    test_abort();
    test_latency1();
    test_churn();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
